// File: rtl/bitsync_lock_ctrl.sv
// Symbol-timing lock sequencer for the Gardner loop.
// Windowed mean |e| drives ACQ/VERIFY/TRACK, loop gain, clear and lock.
module bitsync_lock_ctrl #(
    parameter int WIN_LOG2  = 6,
    parameter int TH_LOCK   = 2048,
    parameter int TH_UNLOCK = 6144,
    parameter int ACQ_MIN   = 4,
    parameter int VERIFY_N  = 3,
    parameter int LOSS_N    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync,
    input  logic signed [15:0] e,
    output logic               gain_sel,
    output logic               loop_clr,
    output logic               lock,
    output logic [1:0]         state,
    output logic [15:0]        err_mean,
    output logic               win_done
);

    localparam int AW = 16 + WIN_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        VERIFY = 2'd2,
        TRACK  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [15:0]         err_mean_q, err_mean_d;
    logic                win_done_q, win_done_d;
    logic [7:0]          acq_cnt_q, acq_cnt_d;
    logic [7:0]          good_cnt_q, good_cnt_d;
    logic [7:0]          bad_cnt_q, bad_cnt_d;
    logic                gain_sel_q, gain_sel_d;
    logic                loop_clr_q, loop_clr_d;
    logic                lock_q, lock_d;

    logic [15:0]         mag;
    logic [AW-1:0]       acc_sum;
    logic [7:0]          acq_inc;
    logic                run;

    // Saturating magnitude of the timing error and running window sum
    always_comb begin
        if (e == 16'sh8000) begin
            mag = 16'h7fff;
        end else if (e[15]) begin
            mag = 16'(-e);
        end else begin
            mag = 16'(e);
        end
        acc_sum = acc_q + AW'(mag);
        acq_inc = (acq_cnt_q == 8'hff) ? acq_cnt_q : acq_cnt_q + 8'd1;
        run     = en && (state_q != IDLE);
    end

    // Window accumulation and lock-state decisions on each closed window
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_mean_d = err_mean_q;
        win_done_d = 1'b0;
        acq_cnt_d  = acq_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        if (!run) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sync) begin
            if (cnt_q != '1) begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end else begin
                err_mean_d = 16'(acc_sum >> WIN_LOG2);
                acc_d      = '0;
                cnt_d      = '0;
                win_done_d = 1'b1;
            end
        end

        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = ACQ;
                    acq_cnt_d  = '0;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
                ACQ: begin
                    if (win_done_q) begin
                        acq_cnt_d = acq_inc;
                        if (acq_inc >= 8'(ACQ_MIN) &&
                            err_mean_q < 16'(TH_LOCK)) begin
                            state_d    = VERIFY;
                            good_cnt_d = 8'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (win_done_q) begin
                        if (err_mean_q < 16'(TH_LOCK)) begin
                            good_cnt_d = good_cnt_q + 8'd1;
                            if (good_cnt_d >= 8'(VERIFY_N)) begin
                                state_d   = TRACK;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            state_d   = ACQ;
                            acq_cnt_d = '0;
                        end
                    end
                end
                TRACK: begin
                    if (win_done_q) begin
                        if (err_mean_q >= 16'(TH_UNLOCK)) begin
                            bad_cnt_d = bad_cnt_q + 8'd1;
                            if (bad_cnt_d >= 8'(LOSS_N)) begin
                                state_d   = ACQ;
                                acq_cnt_d = '0;
                            end
                        end else begin
                            bad_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        loop_clr_d = (state_d == IDLE);
        gain_sel_d = (state_d == TRACK);
        lock_d     = (state_d == TRACK);
    end

    // State, window and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_mean_q <= '0;
            win_done_q <= 1'b0;
            acq_cnt_q  <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            gain_sel_q <= 1'b0;
            loop_clr_q <= 1'b1;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_mean_q <= err_mean_d;
            win_done_q <= win_done_d;
            acq_cnt_q  <= acq_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            gain_sel_q <= gain_sel_d;
            loop_clr_q <= loop_clr_d;
            lock_q     <= lock_d;
        end
    end

    assign gain_sel = gain_sel_q;
    assign loop_clr = loop_clr_q;
    assign lock     = lock_q;
    assign state    = state_q;
    assign err_mean = err_mean_q;
    assign win_done = win_done_q;

endmodule

// File: tb/tb_bitsync_lock_ctrl.sv
// Bench for bitsync_lock_ctrl: window-level reference model plus
// directed phase checks and randomized windows.
module tb_bitsync_lock_ctrl;

    localparam int N    = 64;
    localparam int THL  = 2048;
    localparam int THU  = 6144;
    localparam int AMIN = 4;
    localparam int VN   = 3;
    localparam int LN   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               sync = 1'b0;
    logic signed [15:0] e = '0;
    logic               gain_sel;
    logic               loop_clr;
    logic               lock;
    logic [1:0]         state;
    logic [15:0]        err_mean;
    logic               win_done;

    bitsync_lock_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .e        (e),
        .gain_sel (gain_sel),
        .loop_clr (loop_clr),
        .lock     (lock),
        .state    (state),
        .err_mean (err_mean),
        .win_done (win_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int wd_seen = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: mode, window sum/count, last mean, counters
    int m_st, m_sum, m_n, m_mean, m_wd, m_acq, m_good, m_bad;

    function automatic int absval(int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_reset();
        m_st = 0; m_sum = 0; m_n = 0; m_mean = 0;
        m_wd = 0; m_acq = 0; m_good = 0; m_bad = 0;
    endtask

    initial m_reset();
    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        int nst;
        int nwd;
        if (!rst_n) begin
            m_reset();
        end else begin
            nst = m_st;
            nwd = 0;
            if (!en) begin
                nst = 0;
            end else if (m_st == 0) begin
                nst = 1;
                m_acq = 0; m_good = 0; m_bad = 0;
            end else if (m_wd == 1) begin
                if (m_st == 1) begin
                    if (m_acq < 255) m_acq++;
                    if (m_acq >= AMIN && m_mean < THL) begin
                        nst = 2;
                        m_good = 1;
                    end
                end else if (m_st == 2) begin
                    if (m_mean < THL) begin
                        m_good++;
                        if (m_good >= VN) begin
                            nst = 3;
                            m_bad = 0;
                        end
                    end else begin
                        nst = 1;
                        m_acq = 0;
                    end
                end else begin
                    if (m_mean >= THU) begin
                        m_bad++;
                        if (m_bad >= LN) begin
                            nst = 1;
                            m_acq = 0;
                        end
                    end else begin
                        m_bad = 0;
                    end
                end
            end
            if (en && m_st != 0) begin
                if (sync) begin
                    m_sum += absval(int'(e));
                    m_n++;
                    if (m_n == N) begin
                        m_mean = m_sum / N;
                        m_sum = 0;
                        m_n = 0;
                        nwd = 1;
                    end
                end
            end else begin
                m_sum = 0;
                m_n = 0;
            end
            m_st = nst;
            m_wd = nwd;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", int'(state), m_st);
            chk("lock", int'(lock), int'(m_st == 3));
            chk("gain_sel", int'(gain_sel), int'(m_st == 3));
            chk("loop_clr", int'(loop_clr), int'(m_st == 0));
            chk("err_mean", int'(err_mean), m_mean);
            chk("win_done", int'(win_done), m_wd);
            if (win_done) wd_seen++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic one_sync(int v);
        sync = 1'b1;
        e = 16'(v);
        tick();
        sync = 1'b0;
        e = 16'($urandom);
        tick($urandom_range(0, 3));
    endtask

    // sgn: 0 alternating, 1 always negative, 2 random
    task automatic window(int mag, int jit, int sgn, int cnt = N);
        for (int i = 0; i < cnt; i++) begin
            int m;
            bit neg;
            m = mag + int'($urandom_range(0, jit));
            if (sgn == 0) neg = (i % 2) == 1;
            else if (sgn == 1) neg = 1'b1;
            else neg = $urandom_range(0, 1) == 1;
            one_sync(neg ? -m : m);
        end
    endtask

    task automatic windows(int k, int mag);
        repeat (k) window(mag, 0, 0);
        tick(3);
    endtask

    initial begin
        int base;
        tick(3);
        rst_n = 1'b1;
        tick();

        // Idle: syncs ignored while disabled
        repeat (75) begin
            sync = 1'b1;
            e = 16'sd100;
            tick();
            sync = 1'b0;
            tick(3);
        end
        chk("idle_state", int'(state), 0);
        chk("idle_loop_clr", int'(loop_clr), 1);
        chk("idle_lock", int'(lock), 0);
        chk("idle_err_mean", int'(err_mean), 0);
        chk("idle_win_done_cnt", wd_seen, 0);

        // Acquire: VERIFY after 4 windows, TRACK after 6
        en = 1'b1;
        tick();
        windows(3, 1000);
        chk("acq_state_w3", int'(state), 1);
        windows(1, 1000);
        chk("acq_state_w4", int'(state), 2);
        chk("acq_mean", int'(err_mean), 1000);
        windows(2, 1000);
        chk("acq_state_w6", int'(state), 3);
        chk("acq_lock", int'(lock), 1);
        chk("acq_gain", int'(gain_sel), 1);

        // Hysteresis band and loss of lock
        windows(1, 4000);
        chk("hyst_lock", int'(lock), 1);
        windows(1, 7000);
        windows(1, 4000);
        chk("hyst_reset_state", int'(state), 3);
        windows(2, 7000);
        chk("loss_state", int'(state), 1);
        chk("loss_lock", int'(lock), 0);
        chk("loss_gain", int'(gain_sel), 0);
        chk("loss_mean", int'(err_mean), 7000);

        // Verify failure and re-entry
        windows(4, 1000);
        chk("vf_enter", int'(state), 2);
        windows(1, 3000);
        chk("vf_state", int'(state), 1);
        chk("vf_mean", int'(err_mean), 3000);
        windows(3, 1000);
        chk("vf_still_acq", int'(state), 1);
        windows(1, 1000);
        chk("vf_reenter", int'(state), 2);

        // Saturation: all -32768
        window(32768, 0, 1);
        tick(3);
        chk("sat_mean", int'(err_mean), 32767);
        chk("sat_state", int'(state), 1);

        // Abort from TRACK with a coincident sync
        windows(4, 1000);
        windows(2, 1000);
        chk("abort_pre_track", int'(state), 3);
        window(1000, 0, 0, 30);
        sync = 1'b1;
        e = 16'sd500;
        en = 1'b0;
        tick();
        sync = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_loop_clr", int'(loop_clr), 1);
        chk("abort_lock", int'(lock), 0);
        tick(2);
        en = 1'b1;
        tick();
        base = wd_seen;
        window(1200, 0, 0, 63);
        tick(3);
        chk("restart_63", wd_seen - base, 0);
        one_sync(1200);
        tick(2);
        chk("restart_64", wd_seen - base, 1);
        chk("restart_mean", int'(err_mean), 1200);

        // Reset mid-window
        window(500, 0, 0, 20);
        rst_n = 1'b0;
        tick(2);
        chk("rst_state", int'(state), 0);
        chk("rst_mean", int'(err_mean), 0);
        rst_n = 1'b1;
        tick(2);

        // Randomized windows with occasional enable drops
        for (int w = 0; w < 14; w++) begin
            int mg;
            mg = int'($urandom_range(0, 9000));
            window(mg, int'($urandom_range(0, 1500)), 2,
                   int'($urandom_range(20, 64)));
            if ($urandom_range(0, 6) == 0) begin
                en = 1'b0;
                tick(int'($urandom_range(1, 3)));
                en = 1'b1;
            end
        end
        window(0, 32767, 2, 200);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitsync_lock_ctrl.md
Name: bitsync_lock_ctrl

Overview:
- Acquisition/tracking sequencer for the Gardner symbol-timing loop.
- Watches the loop's timing error at each symbol strobe and computes a windowed mean of |e|.
- From that mean it selects wide or narrow loop bandwidth, clears the loop on restart, and declares symbol-timing lock to the downstream carrier-recovery loop.
- Sits beside the bit-sync block, in the 4x-symbol-rate clock domain.

Parameters:
- WIN_LOG2, 6: window length is 2^WIN_LOG2 symbol strobes.
- TH_LOCK, 2048: a window is "good" when mean |e| < TH_LOCK.
- TH_UNLOCK, 6144: in tracking, a window is "bad" when mean |e| >= TH_UNLOCK. Must be >= TH_LOCK.
- ACQ_MIN, 4: minimum completed windows spent in ACQ before VERIFY is allowed.
- VERIFY_N, 3: consecutive good windows needed to reach TRACK.
- LOSS_N, 2: consecutive bad windows in TRACK that force return to ACQ.

Ports:
- clk  in  1  system clock (4x symbol rate)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; 1 = run, 0 = hold controller in IDLE
- sync  in  1  one-cycle symbol strobe from bit sync
- e  in  16  signed timing error; valid when sync=1
- gain_sel  out  1  0 = wide (acquisition) loop gain, 1 = narrow (tracking)
- loop_clr  out  1  1 = hold Gardner loop filter/NCO in cleared state
- lock  out  1  symbol-timing lock
- state  out  2  IDLE=0, ACQ=1, VERIFY=2, TRACK=3
- err_mean  out  16  unsigned mean |e| of the last completed window
- win_done  out  1  one-cycle pulse when err_mean updates

Behaviour:
- Reset (rst_n=0, asynchronous) clears all registers:
  - state=IDLE, gain_sel=0, loop_clr=1, lock=0, err_mean=0, win_done=0.
  - Accumulator and all counters = 0.
- Decided interface: one clock; reset is asynchronous and active-low (rst_n).
- Outputs are registered decodes of state:
  - loop_clr=1 only in IDLE.
  - gain_sel=1 and lock=1 only in TRACK.
- Magnitude: |e| = -e for negative e; e=-32768 saturates to 32767.
- Accumulator is 16+WIN_LOG2 bits unsigned and never overflows.
- Window operation, only when state != IDLE and sync=1:
  - If the window counter < 2^WIN_LOG2-1: acc += |e|, counter += 1.
  - Else: err_mean <= (acc+|e|) >> WIN_LOG2 (truncate), acc <= 0, counter <= 0, and win_done=1 on the following cycle.
- sync is ignored in IDLE. The accumulator and counter are held at 0 in IDLE.
- Decisions are taken in the win_done cycle using the new err_mean; state updates at the next clock edge.
- IDLE:
  - en=1 -> ACQ, with window, acc_cnt, good_cnt and bad_cnt all cleared.
- ACQ:
  - On each win_done, acq_cnt += 1 (saturating).
  - If acq_cnt (including this window) >= ACQ_MIN and err_mean < TH_LOCK -> VERIFY, good_cnt=1.
- VERIFY:
  - win_done with err_mean < TH_LOCK: good_cnt += 1; at VERIFY_N -> TRACK, bad_cnt=0.
  - win_done with err_mean >= TH_LOCK: -> ACQ, acq_cnt=0.
- TRACK:
  - win_done with err_mean >= TH_UNLOCK: bad_cnt += 1; at LOSS_N -> ACQ, acq_cnt=0.
  - win_done with err_mean < TH_UNLOCK: bad_cnt=0 (hysteresis band).
- en=0 in any state -> IDLE on the next edge. This overrides any simultaneous win_done decision.
- Windows are not restarted on ACQ/VERIFY/TRACK transitions; they run back-to-back.
- A sync that coincides with win_done is accumulated normally into the new window.
- A sync on the cycle en falls is discarded (next state is IDLE).
- Latency:
  - Window-closing sync -> err_mean/win_done: 1 cycle.
  - win_done -> state/lock/gain_sel change: 1 cycle.
- Reset asserted mid-window: all state lost; the restart window begins from 0.

Test Plan:
- Reset/idle: rst_n=0 then 1, en=0, sync every 4 clk with e=100 for 300 clk -> state=0, loop_clr=1, lock=0, err_mean=0, win_done never pulses.
- Acquire: en=1, e=+/-1000 alternating every sync, 64-sync windows -> err_mean=1000 each window. ACQ for 4 windows, VERIFY after window 4, TRACK after window 6. lock=1, gain_sel=1 one cycle after the 6th win_done.
- Verify fail: reach VERIFY, then one window with e=3000 -> err_mean=3000, back to ACQ. VERIFY is re-entered only after 4 further good windows.
- Hysteresis/loss: in TRACK, windows with e=4000 -> lock stays 1. One window at e=7000 then e=4000 -> no loss (bad_cnt cleared). Two consecutive windows at e=7000 -> state=ACQ, lock=0, gain_sel=0.
- Saturation/width: e=-32768 for every sync of a window -> err_mean=32767, no accumulator wrap.
- Abort: drop en mid-window while in TRACK, coincident with a sync -> state=IDLE next edge, loop_clr=1, lock=0. On re-enable, the first win_done occurs after exactly 64 new syncs.
